mips_cpu_exec_core: RTL and testbench

//   Execute-side datapath core of the multicycle MIPS-I CPU: a 32x32 register file, a

---
 rtl/mips_cpu_exec_core.sv | 240 ++++++++++++++++++++++++
 tb/tb_mips_cpu_exec_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_exec_core.sv
// Execute-side datapath of the multicycle MIPS-I CPU: 32x32 register file,
// combinational ALU with branch evaluation, and a HI/LO unit with a
// single-cycle multiplier and an iterative restoring divider.
module mips_cpu_exec_core #(
   parameter int unsigned DIV_BITS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs_idx,
   input  logic [4:0]  rt_idx,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data,
   input  logic [4:0]  wr_idx,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   output logic [31:0] register_v0,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [15:0] imm,
   output logic [31:0] alu_out,
   output logic        carry_out,
   output logic        zero,
   output logic        branch_taken,
   output logic        link,
   input  logic        hilo_en,
   input  logic        div_start,
   output logic        div_busy,
   output logic        div_done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned CntW = $clog2(DIV_BITS + 1);

   typedef enum logic {StIdle, StRun} div_state_e;

   logic [31:0] regs_q [32];

   // Register file: r0 is never written, so it always reads zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      end else if (wr_en && (wr_idx != 5'd0)) begin
         regs_q[wr_idx] <= wr_data;
      end
   end

   assign rs_data     = (rs_idx == 5'd0) ? 32'd0 : regs_q[rs_idx];
   assign rt_data     = (rt_idx == 5'd0) ? 32'd0 : regs_q[rt_idx];
   assign register_v0 = regs_q[2];

   logic [31:0] a, b, sext_imm, zext_imm;
   logic [32:0] add_ab, add_ai, sub_ab;

   assign a        = rs_data;
   assign b        = rt_data;
   assign sext_imm = {{16{imm[15]}}, imm};
   assign zext_imm = {16'd0, imm};
   assign add_ab   = {1'b0, a} + {1'b0, b};
   assign add_ai   = {1'b0, a} + {1'b0, sext_imm};
   assign sub_ab   = {1'b0, a} - {1'b0, b};

   // ALU result and carry/borrow
   always_comb begin
      alu_out   = 32'd0;
      carry_out = 1'b0;
      unique case (opcode)
         6'h00: begin
            unique case (funct)
               6'h00: alu_out = b << shamt;
               6'h02: alu_out = b >> shamt;
               6'h03: alu_out = $unsigned($signed(b) >>> shamt);
               6'h04: alu_out = b << a[4:0];
               6'h06: alu_out = b >> a[4:0];
               6'h07: alu_out = $unsigned($signed(b) >>> a[4:0]);
               6'h20: alu_out = add_ab[31:0];
               6'h21: begin
                  alu_out   = add_ab[31:0];
                  carry_out = add_ab[32];
               end
               6'h22: alu_out = sub_ab[31:0];
               6'h23: begin
                  alu_out   = sub_ab[31:0];
                  carry_out = sub_ab[32];
               end
               6'h24: alu_out = a & b;
               6'h25: alu_out = a | b;
               6'h26: alu_out = a ^ b;
               6'h27: alu_out = ~(a | b);
               6'h2A: alu_out = {31'd0, $signed(a) < $signed(b)};
               6'h2B: alu_out = {31'd0, a < b};
               default: alu_out = 32'd0;
            endcase
         end
         // ADDIU and every load/store use the address adder
         6'h09, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
         6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
            alu_out   = add_ai[31:0];
            carry_out = add_ai[32];
         end
         6'h0A: alu_out = {31'd0, $signed(a) < $signed(sext_imm)};
         6'h0B: alu_out = {31'd0, a < sext_imm};
         6'h0C: alu_out = a & zext_imm;
         6'h0D: alu_out = a | zext_imm;
         6'h0E: alu_out = a ^ zext_imm;
         6'h0F: alu_out = {imm, 16'h0000};
         default: begin
            alu_out   = 32'd0;
            carry_out = 1'b0;
         end
      endcase
   end

   assign zero = (alu_out == 32'd0);

   // Branch condition and link for REGIMM
   always_comb begin
      branch_taken = 1'b0;
      link         = 1'b0;
      unique case (opcode)
         6'h01: begin
            unique case (rt_idx)
               5'b00000: branch_taken = a[31];
               5'b00001: branch_taken = ~a[31];
               5'b10000: begin
                  branch_taken = a[31];
                  link         = 1'b1;
               end
               5'b10001: begin
                  branch_taken = ~a[31];
                  link         = 1'b1;
               end
               default: branch_taken = 1'b0;
            endcase
         end
         6'h04: branch_taken = (a == b);
         6'h05: branch_taken = (a != b);
         6'h06: branch_taken = a[31] | (a == 32'd0);
         6'h07: branch_taken = ~a[31] & (a != 32'd0);
         default: branch_taken = 1'b0;
      endcase
   end

   logic signed [63:0] mul_s;
   logic        [63:0] mul_u;

   assign mul_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign mul_u = {32'd0, a} * {32'd0, b};

   div_state_e      state_q;
   logic [CntW-1:0] cnt_q;
   logic [31:0]     rem_q, quo_q, dvsr_q, dvnd_q;
   logic            neg_q_q, neg_r_q, dz_q, done_q;
   logic [31:0]     hi_q, lo_q;

   // One restoring step: shift in the next dividend bit, subtract if it fits
   logic [32:0] rem_sh, rem_diff;
   logic        q_bit;
   logic [31:0] rem_nx, quo_nx, q_fin, r_fin;

   always_comb begin
      rem_sh   = {rem_q, quo_q[31]};
      rem_diff = rem_sh - {1'b0, dvsr_q};
      q_bit    = (rem_sh >= {1'b0, dvsr_q});
      rem_nx   = q_bit ? rem_diff[31:0] : rem_sh[31:0];
      quo_nx   = {quo_q[30:0], q_bit};
      q_fin    = neg_q_q ? (32'd0 - quo_nx) : quo_nx;
      r_fin    = neg_r_q ? (32'd0 - rem_nx) : rem_nx;
   end

   logic        start_ok, div_signed, a_neg, b_neg;

   assign div_signed = (funct == 6'h1A);
   assign start_ok   = div_start && (state_q == StIdle) &&
                       ((funct == 6'h1A) || (funct == 6'h1B));
   assign a_neg      = div_signed & a[31];
   assign b_neg      = div_signed & b[31];

   // Divider FSM plus HI/LO commit; multiply/move writes are locked out while dividing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         dvnd_q  <= '0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         dz_q    <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_ok) begin
                  state_q <= StRun;
                  cnt_q   <= '0;
                  rem_q   <= '0;
                  quo_q   <= a_neg ? (32'd0 - a) : a;
                  dvsr_q  <= b_neg ? (32'd0 - b) : b;
                  dvnd_q  <= a;
                  neg_q_q <= a_neg ^ b_neg;
                  neg_r_q <= a_neg;
                  dz_q    <= (b == 32'd0);
               end else if (hilo_en) begin
                  unique case (funct)
                     6'h18: {hi_q, lo_q} <= mul_s;
                     6'h19: {hi_q, lo_q} <= mul_u;
                     6'h11: hi_q <= a;
                     6'h13: lo_q <= a;
                     default: ;
                  endcase
               end
            end
            StRun: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CntW'(DIV_BITS - 1)) begin
                  state_q <= StIdle;
                  done_q  <= 1'b1;
                  lo_q    <= dz_q ? 32'hFFFF_FFFF : q_fin;
                  hi_q    <= dz_q ? dvnd_q : r_fin;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign div_busy = (state_q == StRun);
   assign div_done = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: tb/tb_mips_cpu_exec_core.sv
// Directed self-checking bench for mips_cpu_exec_core.
module tb_mips_cpu_exec_core;

   logic        clk, reset;
   logic [4:0]  rs_idx, rt_idx, wr_idx, shamt;
   logic [31:0] rs_data, rt_data, wr_data, register_v0, alu_out, hi, lo;
   logic        wr_en, carry_out, zero, branch_taken, link;
   logic        hilo_en, div_start, div_busy, div_done;
   logic [5:0]  opcode, funct;
   logic [15:0] imm;

   int checks = 0;
   int failures = 0;

   mips_cpu_exec_core #(.DIV_BITS(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .rs_idx       (rs_idx),
      .rt_idx       (rt_idx),
      .rs_data      (rs_data),
      .rt_data      (rt_data),
      .wr_idx       (wr_idx),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .register_v0  (register_v0),
      .opcode       (opcode),
      .funct        (funct),
      .shamt        (shamt),
      .imm          (imm),
      .alu_out      (alu_out),
      .carry_out    (carry_out),
      .zero         (zero),
      .branch_taken (branch_taken),
      .link         (link),
      .hilo_en      (hilo_en),
      .div_start    (div_start),
      .div_busy     (div_busy),
      .div_done     (div_done),
      .hi           (hi),
      .lo           (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [4:0] idx, input logic [31:0] d);
      wr_idx  = idx;
      wr_data = d;
      wr_en   = 1'b1;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic set_op(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] sh, input logic [15:0] im);
      opcode = op;
      funct  = fn;
      rs_idx = rs;
      rt_idx = rt;
      shamt  = sh;
      imm    = im;
      #1;
   endtask

   // Starts a divide and returns the edge count (start edge = 1) until div_done, 0 on timeout
   task automatic run_div(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                          output int edges);
      set_op(6'h00, fn, rs, rt, 5'd0, 16'h0);
      div_start = 1'b1;
      tick();
      div_start = 1'b0;
      edges = 1;
      while (!div_done && edges < 100) begin
         tick();
         edges++;
      end
      if (!div_done) edges = 0;
   endtask

   int  n;
   logic seen;

   initial begin
      reset = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0; hilo_en = 1'b0; div_start = 1'b0;
      opcode = '0; funct = '0; shamt = '0; imm = '0; rs_idx = 5'd5; rt_idx = 5'd2;
      #11;
      check_eq("rst_rs", rs_data, 32'd0);
      check_eq("rst_hi", hi, 32'd0);
      check_eq("rst_busy", {31'd0, div_busy}, 32'd0);
      #1 reset = 1'b1;
      tick();

      // Register file
      write_reg(5'd5, 32'h1234_5678);
      write_reg(5'd0, 32'hFFFF_FFFF);
      write_reg(5'd2, 32'hCAFE_F00D);
      set_op(6'h00, 6'h3F, 5'd5, 5'd0, 5'd0, 16'h0);
      check_eq("rd_r5", rs_data, 32'h1234_5678);
      check_eq("rd_r0", rt_data, 32'd0);
      check_eq("v0", register_v0, 32'hCAFE_F00D);
      check_eq("unk_funct", alu_out, 32'd0);
      rs_idx = 5'd12; wr_idx = 5'd12; wr_data = 32'h0000_AAAA; wr_en = 1'b1; #1;
      check_eq("no_bypass", rs_data, 32'd0);
      tick();
      wr_en = 1'b0;
      check_eq("after_wr", rs_data, 32'h0000_AAAA);

      write_reg(5'd1, 32'hFFFF_FFFF);
      write_reg(5'd3, 32'd1);
      write_reg(5'd4, 32'h8000_0000);
      write_reg(5'd6, 32'd5);
      write_reg(5'd7, 32'hFFFF_FFFE);
      write_reg(5'd8, 32'd3);
      write_reg(5'd9, 32'hFFFF_FFF9);
      write_reg(5'd10, 32'd2);

      // ALU
      set_op(6'h00, 6'h21, 5'd1, 5'd3, 5'd0, 16'h0);
      check_eq("addu", alu_out, 32'd0);
      check_eq("addu_c", {31'd0, carry_out}, 32'd1);
      check_eq("addu_z", {31'd0, zero}, 32'd1);
      set_op(6'h00, 6'h03, 5'd0, 5'd4, 5'd4, 16'h0);
      check_eq("sra", alu_out, 32'hF800_0000);
      set_op(6'h00, 6'h23, 5'd3, 5'd6, 5'd0, 16'h0);
      check_eq("subu", alu_out, 32'hFFFF_FFFC);
      check_eq("subu_b", {31'd0, carry_out}, 32'd1);
      set_op(6'h00, 6'h2A, 5'd7, 5'd8, 5'd0, 16'h0);
      check_eq("slt", alu_out, 32'd1);
      set_op(6'h0A, 6'h00, 5'd1, 5'd0, 5'd0, 16'h0001);
      check_eq("slti", alu_out, 32'd1);
      set_op(6'h0B, 6'h00, 5'd6, 5'd0, 5'd0, 16'hFFFF);
      check_eq("sltiu", alu_out, 32'd1);
      set_op(6'h0F, 6'h00, 5'd0, 5'd0, 5'd0, 16'hBFC0);
      check_eq("lui", alu_out, 32'hBFC0_0000);
      set_op(6'h23, 6'h00, 5'd6, 5'd0, 5'd0, 16'hFFFC);
      check_eq("lw_addr", alu_out, 32'd1);
      check_eq("lw_c", {31'd0, carry_out}, 32'd1);

      // Branches
      set_op(6'h01, 6'h00, 5'd0, 5'b10001, 5'd0, 16'h0);
      check_eq("bgezal_t", {31'd0, branch_taken}, 32'd1);
      check_eq("bgezal_l", {31'd0, link}, 32'd1);
      set_op(6'h01, 6'h00, 5'd1, 5'b00000, 5'd0, 16'h0);
      check_eq("bltz_t", {31'd0, branch_taken}, 32'd1);
      check_eq("bltz_l", {31'd0, link}, 32'd0);
      set_op(6'h06, 6'h00, 5'd3, 5'd0, 5'd0, 16'h0);
      check_eq("blez", {31'd0, branch_taken}, 32'd0);
      set_op(6'h05, 6'h00, 5'd6, 5'd6, 5'd0, 16'h0);
      check_eq("bne", {31'd0, branch_taken}, 32'd0);
      set_op(6'h07, 6'h00, 5'd6, 5'd0, 5'd0, 16'h0);
      check_eq("bgtz", {31'd0, branch_taken}, 32'd1);

      // HI/LO
      set_op(6'h00, 6'h18, 5'd7, 5'd8, 5'd0, 16'h0);
      hilo_en = 1'b1; tick(); hilo_en = 1'b0;
      check_eq("mult_hi", hi, 32'hFFFF_FFFF);
      check_eq("mult_lo", lo, 32'hFFFF_FFFA);
      set_op(6'h00, 6'h19, 5'd1, 5'd1, 5'd0, 16'h0);
      hilo_en = 1'b1; tick(); hilo_en = 1'b0;
      check_eq("multu_hi", hi, 32'hFFFF_FFFE);
      check_eq("multu_lo", lo, 32'd1);
      set_op(6'h00, 6'h13, 5'd6, 5'd0, 5'd0, 16'h0);
      hilo_en = 1'b1; tick(); hilo_en = 1'b0;
      check_eq("mtlo", lo, 32'd5);

      // DIV -7/2, with an MTHI attempt while busy that must be ignored
      set_op(6'h00, 6'h1A, 5'd9, 5'd10, 5'd0, 16'h0);
      div_start = 1'b1;
      tick();
      div_start = 1'b0;
      check_eq("div_busy", {31'd0, div_busy}, 32'd1);
      funct = 6'h11; rs_idx = 5'd6; hilo_en = 1'b1;
      n = 1;
      while (!div_done && n < 100) begin
         tick();
         n++;
         if (n == 4) hilo_en = 1'b0;
      end
      hilo_en = 1'b0;
      check_eq("div_lat", n, 33);
      check_eq("div_lo", lo, 32'hFFFF_FFFD);
      check_eq("div_hi", hi, 32'hFFFF_FFFF);
      tick();
      check_eq("done_pulse", {31'd0, div_done}, 32'd0);
      check_eq("busy_drop", {31'd0, div_busy}, 32'd0);

      run_div(6'h1B, 5'd6, 5'd0, n);
      check_eq("divu0_lat", n, 33);
      check_eq("divu0_lo", lo, 32'hFFFF_FFFF);
      check_eq("divu0_hi", hi, 32'd5);
      run_div(6'h1A, 5'd9, 5'd0, n);
      check_eq("div0_hi", hi, 32'hFFFF_FFF9);
      run_div(6'h1A, 5'd4, 5'd1, n);
      check_eq("ovf_lo", lo, 32'h8000_0000);
      check_eq("ovf_hi", hi, 32'd0);
      run_div(6'h1B, 5'd1, 5'd8, n);
      check_eq("divu_lo", lo, 32'h5555_5555);

      // Reset at edge 10 of a divide aborts it
      set_op(6'h00, 6'h1A, 5'd9, 5'd10, 5'd0, 16'h0);
      div_start = 1'b1;
      tick();
      div_start = 1'b0;
      for (int i = 2; i <= 10; i++) tick();
      reset = 1'b0;
      #1;
      check_eq("abort_busy", {31'd0, div_busy}, 32'd0);
      check_eq("abort_hi", hi, 32'd0);
      check_eq("abort_lo", lo, 32'd0);
      #2 reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (div_done) seen = 1'b1;
      end
      check_eq("abort_no_done", {31'd0, seen}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
